dmem_responder: RTL and testbench
=================================

# dmem_responder

Target-side data memory for the pipelined RV32IM core. It answers the MEM-stage load/store request (read/write enable, address, store data, FUNC3) after a programmable latency. It holds MEM_BUSYWAIT-style stall high until the access completes. It performs RISC-V byte/half/word lane steering and load sign/zero extension internally, so the CPU sees a plain 32-bit result.

## Interface
Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; power of two
- LATENCY, 3, BUSY cycles per access; minimum 1
- ADDR_W, 8, log2(DEPTH_WORDS)

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  synchronous, active-high reset
- READ  in  1  load request from MEM stage
- WRITE  in  1  store request from MEM stage
- ADDRESS  in  32  byte address
- WRITEDATA  in  32  store data, right-aligned
- FUNC3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- READDATA  out  32  extended load result, registered
- BUSYWAIT  out  1  stall to CPU; combinational from state and request
- MISALIGN  out  1  registered error flag for the completed access (only with the check enabled)

Clock and reset: one clock, CLK; RESET is synchronous and active-high.

## Operation
- FSM states and transitions:
  - IDLE: when READ|WRITE is high, latch ADDRESS, WRITEDATA, FUNC3 and the op (WRITE wins if both are high), load cnt=LATENCY-1, then go to BUSY.
  - BUSY: if cnt==0, perform the access and go to DONE; otherwise decrement cnt.
  - DONE: unconditionally go to IDLE.
- BUSYWAIT = (state==IDLE & (READ|WRITE)) | state==BUSY. It is low in DONE.
- Word index is ADDRESS[ADDR_W+1:2]. Upper address bits are ignored, so accesses wrap modulo DEPTH_WORDS.
- Store lane steering:
  - B writes byte lane ADDRESS[1:0].
  - H writes lanes {A[1],0} and {A[1],1}.
  - W writes all four lanes.
  - Unwritten lanes are preserved.
- Load extension:
  - B sign-extends bit 7 of the selected byte; BU zero-extends.
  - H sign-extends bit 15 of the selected half; HU zero-extends.
  - W passes the word through.
- FUNC3 values 011, 110 and 111 are treated as W.
- READDATA:
  - Updated only on a read leaving BUSY.
  - On a write, or when READ and WRITE are both high, READDATA is loaded with 0.
  - Otherwise it holds its value.
- A latched access always completes. Deasserting READ/WRITE during BUSY does not cancel it.
- A new request arriving in DONE is ignored. It is accepted on the following IDLE cycle if it is still asserted.

## Timing
- Reset values: state=IDLE, cnt=0, READDATA=0, MISALIGN=0, BUSYWAIT=0 when no request is present. Memory contents are not cleared.
- RESET during BUSY aborts the access: no write is committed and the FSM returns to IDLE on that edge.
- Access timeline, with the request first seen in IDLE at cycle 0:
  - BUSYWAIT is high in cycles 0..LATENCY.
  - Cycle LATENCY+1 is DONE: BUSYWAIT is low and READDATA/MISALIGN are valid.
  - The CPU advances at the end of DONE.
- Total stall is LATENCY+1 cycles per access.
- Back-to-back accesses have one dead cycle between them (DONE, then IDLE re-accept), so the period is LATENCY+2.
- The store commits at the edge leaving BUSY. A load in the next access observes it.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - A misaligned H (A[0]=1) or W (A[1:0]≠0) sets MISALIGN=1 in DONE.
  - The store is suppressed and READDATA=0.
  - MISALIGN is cleared when the next access leaves BUSY, and by reset.
- DMEM_ALIGN_CHECK_EN undefined:
  - The MISALIGN port is tied to 0.
  - H ignores A[0] and W ignores A[1:0], so the access is forced to alignment.

## Structure
- Package dmem_pkg holds:
  - the state encoding (IDLE, BUSY, DONE);
  - FUNC3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the 2-bit state width.
- Sub-module dmem_lane_align is purely combinational:
  - Inputs: FUNC3, A[1:0], store data, read word.
  - Outputs: 4-bit byte enable, steered store word, extended load word, misalign flag.
- The top level holds the FSM, the counter, request latches and the storage array.

## Test plan
- Reset then idle: RESET high 2 cycles → READDATA=0, BUSYWAIT=0, state IDLE.
- Word store/load with LATENCY=3: SW 0xDEADBEEF to 0x10, then LW 0x10 → BUSYWAIT high 4 cycles for each access; READDATA=0xDEADBEEF in DONE.
- Byte store/load extension: SB 0x80 to 0x13 over a word of 0x00000000, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80000000.
- Halfword and address wrap: SH 0x8001 to 0x402 with DEPTH_WORDS=256, then LHU 0x002 → 0x00008001; LH → 0xFFFF8001.
- Abort and late-request corner cases:
  - RESET asserted in BUSY of SW 0x11111111 to 0x20, over a word previously holding 0x5 → a subsequent LW 0x20 returns 0x5.
  - Request held high through DONE → accepted exactly once more, with no double write.
- Misalignment with DMEM_ALIGN_CHECK_EN: SW 0xAAAAAAAA to 0x21 → MISALIGN=1 in DONE and memory at 0x20 is unchanged. Without the macro → the store lands at 0x20.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the dmem_responder data memory: FSM state encoding,
// RISC-V FUNC3 load/store size codes and a helper that classifies an access
// by its width.
// Configuration macro used by the users of this package: DMEM_ALIGN_CHECK_EN.
package dmem_pkg;

  // Width of the responder FSM state register
  localparam int STATE_W = 2;

  // FSM states, kept as plain constants so older tools can consume them
  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_BUSY = 2'd1;
  localparam logic [STATE_W-1:0] S_DONE = 2'd2;

  // FUNC3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access width after decoding FUNC3
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } accSize_e;

  // Undefined FUNC3 codes (011, 110, 111) fall through to a full word access
  function automatic accSize_e accessSize(input logic [2:0] func3);
    accSize_e size;
    case (func3)
      F3_B, F3_BU: size = SZ_BYTE;
      F3_H, F3_HU: size = SZ_HALF;
      default:     size = SZ_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align
// Purely combinational byte-lane steering for dmem_responder.
// Ports:
//   func3_i      access size / sign code
//   addrLo_i     byte offset within the word (ADDRESS[1:0])
//   storeData_i  right-aligned store data from the CPU
//   readWord_i   raw 32-bit word read from the storage array
//   byteEn_o     per-byte write enable for the storage array
//   storeWord_o  store data replicated onto the target lanes
//   loadWord_o   sign/zero-extended load result
//   misalign_o   access is misaligned for its width
// When DMEM_ALIGN_CHECK_EN is not defined misalign_o is always 0 and
// half/word accesses are forced to their natural alignment.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addrLo_i,
  input  logic [31:0] storeData_i,
  input  logic [31:0] readWord_i,
  output logic [3:0]  byteEn_o,
  output logic [31:0] storeWord_o,
  output logic [31:0] loadWord_o,
  output logic        misalign_o
);

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  accSize_e   size;
  logic       isUnsigned;
  logic [7:0] selByte;
  logic [15:0] selHalf;

  // Decode width and signedness, then pick lanes. The half path only looks
  // at addrLo_i[1], which is what forces halfwords onto an even boundary.
  always_comb begin
    size        = accessSize(func3_i);
    isUnsigned  = (func3_i == F3_BU) || (func3_i == F3_HU);
    selByte     = readWord_i[{addrLo_i, 3'b000} +: 8];
    selHalf     = addrLo_i[1] ? readWord_i[31:16] : readWord_i[15:0];
    byteEn_o    = 4'b1111;
    storeWord_o = storeData_i;
    loadWord_o  = readWord_i;
    misalign_o  = 1'b0;
    case (size)
      SZ_BYTE: begin
        byteEn_o    = 4'b0001 << addrLo_i;
        storeWord_o = {4{storeData_i[7:0]}};
        loadWord_o  = isUnsigned ? {24'b0, selByte} : {{24{selByte[7]}}, selByte};
      end
      SZ_HALF: begin
        byteEn_o    = addrLo_i[1] ? 4'b1100 : 4'b0011;
        storeWord_o = {2{storeData_i[15:0]}};
        loadWord_o  = isUnsigned ? {16'b0, selHalf} : {{16{selHalf[15]}}, selHalf};
        misalign_o  = ALIGN_CHECK & addrLo_i[0];
      end
      default: begin
        misalign_o  = ALIGN_CHECK & (|addrLo_i);
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Target-side data memory for the pipelined RV32IM core. A load/store seen in
// IDLE is latched, held for LATENCY BUSY cycles, performed on the edge that
// leaves BUSY, and reported in DONE. BUSYWAIT stalls the CPU until DONE.
// Ports:
//   CLK        system clock, rising edge
//   RESET      synchronous active-high reset
//   READ       load request
//   WRITE      store request (wins over READ when both are high)
//   ADDRESS    byte address; bits above the array size are ignored
//   WRITEDATA  right-aligned store data
//   FUNC3      access size / sign code
//   READDATA   registered, extended load result
//   BUSYWAIT   combinational stall to the CPU
//   MISALIGN   registered misalignment flag of the completed access
// Configuration: define DMEM_ALIGN_CHECK_EN to flag and suppress misaligned
// half/word accesses; otherwise MISALIGN stays 0 and accesses are aligned.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3,
  parameter int ADDR_W      = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITEDATA,
  input  logic [2:0]  FUNC3,
  output logic [31:0] READDATA,
  output logic        BUSYWAIT,
  output logic        MISALIGN
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W+1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [2:0]         func3_q;
  logic               isWrite_q;
  logic [31:0]        readData_q;
  logic               misalign_q;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               request;
  logic               accessFire;
  logic [ADDR_W-1:0]  wordIdx;
  logic [31:0]        rawWord;
  logic [3:0]         laneBe;
  logic [3:0]         effBe;
  logic [31:0]        laneStore;
  logic [31:0]        laneLoad;
  logic               laneMis;
  logic               unusedAddrBits;

  // Address bits above the array wrap away; fold them so they are consumed
  assign unusedAddrBits = ^ADDRESS[31:ADDR_W+2];

  assign request    = READ | WRITE;
  assign accessFire = (state_q == S_BUSY) && (cnt_q == '0);
  assign wordIdx    = addr_q[ADDR_W+1:2];
  assign rawWord    = mem[wordIdx];

  dmem_lane_align u_lane (
    .func3_i     (func3_q),
    .addrLo_i    (addr_q[1:0]),
    .storeData_i (wdata_q),
    .readWord_i  (rawWord),
    .byteEn_o    (laneBe),
    .storeWord_o (laneStore),
    .loadWord_o  (laneLoad),
    .misalign_o  (laneMis)
  );

  // A flagged misaligned access must not touch memory
  assign effBe = laneMis ? 4'b0000 : laneBe;

  // Next-state logic: IDLE accepts, BUSY counts down to the access, DONE
  // gives the CPU one cycle to advance before a new request is looked at.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (request) begin
          state_d = S_BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and counter registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latches, captured only on acceptance so that the CPU may drop
  // or change its request while the access is in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      func3_q   <= F3_W;
      isWrite_q <= 1'b0;
    end else if ((state_q == S_IDLE) && request) begin
      addr_q    <= ADDRESS[ADDR_W+1:0];
      wdata_q   <= WRITEDATA;
      func3_q   <= FUNC3;
      isWrite_q <= WRITE;
    end
  end

  // Result registers, updated only as the access leaves BUSY; stores and
  // flagged misaligned loads return 0.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      readData_q <= '0;
      misalign_q <= 1'b0;
    end else if (accessFire) begin
      readData_q <= (isWrite_q || laneMis) ? 32'h0 : laneLoad;
      misalign_q <= laneMis;
    end
  end

  // Storage array; not cleared by reset, and a reset on the commit edge
  // aborts the store.
  always_ff @(posedge CLK) begin
    if (!RESET && accessFire && isWrite_q) begin
      for (int i = 0; i < 4; i++) begin
        if (effBe[i]) begin
          mem[wordIdx][i*8 +: 8] <= laneStore[i*8 +: 8];
        end
      end
    end
  end

  assign BUSYWAIT = ((state_q == S_IDLE) && request) || (state_q == S_BUSY);
  assign READDATA = readData_q;
  assign MISALIGN = misalign_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed and randomized checks of dmem_responder against a byte-array
// reference model. Honours DMEM_ALIGN_CHECK_EN the same way the design does.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT     = 3;
  localparam int DEPTH   = 256;
  localparam int AW      = 8;
  localparam int MAXWAIT = 50;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITEDATA;
  logic [2:0]  FUNC3;
  logic [31:0] READDATA;
  logic        BUSYWAIT;
  logic        MISALIGN;

  int checks = 0;
  int errors = 0;

  logic [7:0]  refBytes [DEPTH*4];
  logic [31:0] expReadData = 32'h0;
  logic        expMisalign = 1'b0;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .ADDR_W      (AW)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .READ      (READ),
    .WRITE     (WRITE),
    .ADDRESS   (ADDRESS),
    .WRITEDATA (WRITEDATA),
    .FUNC3     (FUNC3),
    .READDATA  (READDATA),
    .BUSYWAIT  (BUSYWAIT),
    .MISALIGN  (MISALIGN)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference model: memory as a flat byte array, access as a run of n bytes
  task automatic refAccess(input bit isWr, input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    int          n;
    int          off;
    int          base;
    bit          uns;
    bit          mis;
    logic [31:0] val;
    base = int'(addr[AW+1:2]) * 4;
    case (f3)
      3'b000, 3'b100: n = 1;
      3'b001, 3'b101: n = 2;
      default:        n = 4;
    endcase
    uns = (f3 == 3'b100) || (f3 == 3'b101);
    mis = CHECK_EN && (int'(addr[1:0]) % n != 0);
    off = (int'(addr[1:0]) / n) * n;
    expMisalign = mis;
    if (isWr) begin
      if (!mis) begin
        for (int k = 0; k < n; k++) refBytes[base + off + k] = data[8*k +: 8];
      end
      expReadData = 32'h0;
    end else if (mis) begin
      expReadData = 32'h0;
    end else begin
      val = 32'h0;
      for (int k = 0; k < n; k++) val[8*k +: 8] = refBytes[base + off + k];
      if (!uns && n < 4 && val[8*n-1]) begin
        for (int k = n; k < 4; k++) val[8*k +: 8] = 8'hFF;
      end
      expReadData = val;
    end
  endtask

  // One complete access: request in IDLE, count stall cycles, check DONE,
  // then step into the following IDLE cycle.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [2:0] f3,
                               input bit hold, input string tag);
    int cycles;
    READ      = rd;
    WRITE     = wr;
    ADDRESS   = addr;
    WRITEDATA = data;
    FUNC3     = f3;
    #1;
    cycles = 0;
    while (BUSYWAIT === 1'b1 && cycles < MAXWAIT) begin
      cycles++;
      @(posedge CLK);
      #1;
      if (!hold) begin
        READ  = 1'b0;
        WRITE = 1'b0;
      end
      #1;
    end
    refAccess(wr, addr, data, f3);
    checkOutput({tag, " stall cycles"}, 32'(cycles), 32'(LAT + 1));
    checkOutput({tag, " busywait in DONE"}, {31'b0, BUSYWAIT}, 32'h0);
    checkOutput({tag, " readdata"}, READDATA, expReadData);
    checkOutput({tag, " misalign"}, {31'b0, MISALIGN}, {31'b0, expMisalign});
    tick;
  endtask

  initial begin
    RESET     = 1'b1;
    READ      = 1'b0;
    WRITE     = 1'b0;
    ADDRESS   = 32'h0;
    WRITEDATA = 32'h0;
    FUNC3     = F3_W;
    tick;
    tick;
    RESET = 1'b0;
    #1;
    checkOutput("reset readdata", READDATA, 32'h0);
    checkOutput("reset busywait", {31'b0, BUSYWAIT}, 32'h0);
    checkOutput("reset misalign", {31'b0, MISALIGN}, 32'h0);

    $display("[TB] preloading memory");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 32'(i * 4), $urandom, F3_W, 1'b0, "preload SW");
    end

    $display("[TB] word store/load");
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, F3_W, 1'b0, "SW 0x10");
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, F3_W, 1'b0, "LW 0x10");
    checkOutput("LW 0x10 const", READDATA, 32'hDEADBEEF);

    $display("[TB] byte store/load extension");
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h0, F3_W, 1'b0, "SW 0 to 0x10");
    applyStimulus(1'b0, 1'b1, 32'h13, 32'h80, F3_B, 1'b0, "SB 0x13");
    applyStimulus(1'b1, 1'b0, 32'h13, 32'h0, F3_B, 1'b0, "LB 0x13");
    checkOutput("LB 0x13 const", READDATA, 32'hFFFFFF80);
    applyStimulus(1'b1, 1'b0, 32'h13, 32'h0, F3_BU, 1'b0, "LBU 0x13");
    checkOutput("LBU 0x13 const", READDATA, 32'h00000080);
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, F3_W, 1'b0, "LW 0x10 after SB");
    checkOutput("LW 0x10 after SB const", READDATA, 32'h80000000);

    $display("[TB] halfword and address wrap");
    applyStimulus(1'b0, 1'b1, 32'h402, 32'h8001, F3_H, 1'b0, "SH 0x402");
    applyStimulus(1'b1, 1'b0, 32'h002, 32'h0, F3_HU, 1'b0, "LHU 0x002");
    checkOutput("LHU 0x002 const", READDATA, 32'h00008001);
    applyStimulus(1'b1, 1'b0, 32'h002, 32'h0, F3_H, 1'b0, "LH 0x002");
    checkOutput("LH 0x002 const", READDATA, 32'hFFFF8001);

    $display("[TB] reset during BUSY");
    applyStimulus(1'b0, 1'b1, 32'h20, 32'h5, F3_W, 1'b0, "SW 5 to 0x20");
    READ      = 1'b0;
    WRITE     = 1'b1;
    ADDRESS   = 32'h20;
    WRITEDATA = 32'h11111111;
    FUNC3     = F3_W;
    tick;
    WRITE = 1'b0;
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    #1;
    expReadData = 32'h0;
    expMisalign = 1'b0;
    checkOutput("abort busywait", {31'b0, BUSYWAIT}, 32'h0);
    checkOutput("abort readdata", READDATA, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, F3_W, 1'b0, "LW 0x20 after abort");
    checkOutput("LW 0x20 after abort const", READDATA, 32'h5);

    $display("[TB] request held through DONE");
    applyStimulus(1'b0, 1'b1, 32'h40, 32'h12345678, F3_W, 1'b1, "held SW first");
    applyStimulus(1'b0, 1'b1, 32'h40, 32'h12345678, F3_W, 1'b0, "held SW re-accept");
    #1;
    checkOutput("no third accept", {31'b0, BUSYWAIT}, 32'h0);
    tick;
    checkOutput("still idle", {31'b0, BUSYWAIT}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, F3_W, 1'b0, "LW 0x40");
    checkOutput("LW 0x40 const", READDATA, 32'h12345678);

    $display("[TB] read and write together");
    applyStimulus(1'b1, 1'b1, 32'h44, 32'hCAFEF00D, F3_W, 1'b0, "RW both 0x44");
    checkOutput("RW both readdata const", READDATA, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, F3_W, 1'b0, "LW 0x44");
    checkOutput("LW 0x44 const", READDATA, 32'hCAFEF00D);

    $display("[TB] misaligned word store");
    applyStimulus(1'b0, 1'b1, 32'h21, 32'hAAAAAAAA, F3_W, 1'b0, "SW 0x21");
    checkOutput("SW 0x21 misalign const", {31'b0, MISALIGN}, {31'b0, CHECK_EN});
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, F3_W, 1'b0, "LW 0x20 after SW 0x21");
    checkOutput("LW 0x20 after SW 0x21 const", READDATA, CHECK_EN ? 32'h5 : 32'hAAAAAAAA);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 150; i++) begin
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  f3;
      kind = $urandom_range(0, 2);
      addr = $urandom;
      data = $urandom;
      f3   = 3'($urandom_range(0, 7));
      applyStimulus(kind != 1, kind != 0, addr, data, f3, 1'b0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
